// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS state-control/CDC stage.
// Per point: present wave/ftw, settle 2 cycles, hold apply pulse, then dwell.
module dds_sweep_ctrl #(
   parameter int PULSE_W   = 2,
   parameter int MIN_DWELL = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] cfg_start_ftw,
   input  logic [31:0] cfg_stop_ftw,
   input  logic [31:0] cfg_step_ftw,
   input  logic [23:0] cfg_dwell,
   input  logic [2:0]  cfg_wave_sel,
   input  logic        cfg_continuous,
   output logic [2:0]  wave_sel_out,
   output logic [31:0] ftw_out,
   output logic        apply_pulse,
   output logic        busy,
   output logic        done,
   output logic [15:0] point_idx
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_PULSE  = 2'd2;
   localparam logic [1:0] S_DWELL  = 2'd3;

   localparam logic [23:0] MIN_DW  = 24'(MIN_DWELL);
   localparam logic [23:0] PW_LAST = 24'(PULSE_W - 1);

   logic [1:0]  state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [31:0] ftw_q, ftw_d;
   logic [2:0]  wave_q, wave_d;
   logic        apply_q, apply_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] idx_q, idx_d;
   logic        last_q, last_d;
   logic [31:0] sh_start_q, sh_start_d;
   logic [31:0] sh_stop_q, sh_stop_d;
   logic [31:0] sh_step_q, sh_step_d;
   logic [23:0] sh_dwell_q, sh_dwell_d;
   logic        sh_cont_q, sh_cont_d;

   logic [32:0] sum;
   logic        sh_degen;

   assign sum      = {1'b0, ftw_q} + {1'b0, sh_step_q};
   assign sh_degen = (sh_step_q == '0) || (sh_start_q >= sh_stop_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ftw_d      = ftw_q;
      wave_d     = wave_q;
      apply_d    = apply_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      idx_d      = idx_q;
      last_d     = last_q;
      sh_start_d = sh_start_q;
      sh_stop_d  = sh_stop_q;
      sh_step_d  = sh_step_q;
      sh_dwell_d = sh_dwell_q;
      sh_cont_d  = sh_cont_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               sh_start_d = cfg_start_ftw;
               sh_stop_d  = cfg_stop_ftw;
               sh_step_d  = cfg_step_ftw;
               sh_dwell_d = (cfg_dwell < MIN_DW) ? MIN_DW : cfg_dwell;
               sh_cont_d  = cfg_continuous;
               ftw_d      = cfg_start_ftw;
               wave_d     = cfg_wave_sel;
               idx_d      = '0;
               busy_d     = 1'b1;
               last_d     = (cfg_step_ftw == '0) || (cfg_start_ftw >= cfg_stop_ftw);
               cnt_d      = '0;
               state_d    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == 24'd1) begin
               cnt_d   = '0;
               apply_d = 1'b1;
               state_d = S_PULSE;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         S_PULSE: begin
            if (cnt_q == PW_LAST) begin
               cnt_d   = '0;
               apply_d = 1'b0;
               state_d = S_DWELL;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
         default: begin
            if (cnt_q == sh_dwell_q - 24'd1) begin
               cnt_d = '0;
               if (!last_q) begin
                  // carry out or reaching stop clamps to stop, which ends the sweep
                  if (sum[32] || (sum[31:0] >= sh_stop_q)) begin
                     ftw_d  = sh_stop_q;
                     last_d = 1'b1;
                  end else begin
                     ftw_d  = sum[31:0];
                     last_d = 1'b0;
                  end
                  idx_d   = (idx_q == '1) ? idx_q : idx_q + 16'd1;
                  state_d = S_SETTLE;
               end else if (sh_cont_q) begin
                  ftw_d   = sh_start_q;
                  last_d  = sh_degen;
                  idx_d   = '0;
                  state_d = S_SETTLE;
               end else begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         apply_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ftw_q      <= '0;
         wave_q     <= '0;
         apply_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         idx_q      <= '0;
         last_q     <= 1'b0;
         sh_start_q <= '0;
         sh_stop_q  <= '0;
         sh_step_q  <= '0;
         sh_dwell_q <= '0;
         sh_cont_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ftw_q      <= ftw_d;
         wave_q     <= wave_d;
         apply_q    <= apply_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         sh_start_q <= sh_start_d;
         sh_stop_q  <= sh_stop_d;
         sh_step_q  <= sh_step_d;
         sh_dwell_q <= sh_dwell_d;
         sh_cont_q  <= sh_cont_d;
      end
   end

   assign wave_sel_out = wave_q;
   assign ftw_out      = ftw_q;
   assign apply_pulse  = apply_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign point_idx    = idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with default PULSE_W=2, MIN_DWELL=8.
module tb_dds_sweep_ctrl;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        start, abort;
   logic [31:0] cfg_start_ftw, cfg_stop_ftw, cfg_step_ftw;
   logic [23:0] cfg_dwell;
   logic [2:0]  cfg_wave_sel;
   logic        cfg_continuous;
   logic [2:0]  wave_sel_out;
   logic [31:0] ftw_out;
   logic        apply_pulse, busy, done;
   logic [15:0] point_idx;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [31:0] exp_ftw [$];
   logic [2:0]  exp_wave;
   logic [31:0] held_ftw;
   logic [15:0] held_idx;

   dds_sweep_ctrl #(.PULSE_W(2), .MIN_DWELL(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .start(start), .abort(abort),
      .cfg_start_ftw(cfg_start_ftw), .cfg_stop_ftw(cfg_stop_ftw),
      .cfg_step_ftw(cfg_step_ftw), .cfg_dwell(cfg_dwell),
      .cfg_wave_sel(cfg_wave_sel), .cfg_continuous(cfg_continuous),
      .wave_sel_out(wave_sel_out), .ftw_out(ftw_out), .apply_pulse(apply_pulse),
      .busy(busy), .done(done), .point_idx(point_idx)
   );

   always #5 Clk = ~Clk;

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                          input logic [23:0] dw, input logic [2:0] w, input logic c);
      cfg_start_ftw = s; cfg_stop_ftw = e; cfg_step_ftw = st;
      cfg_dwell = dw; cfg_wave_sel = w; cfg_continuous = c;
   endtask

   // Called just after E0; walks every point in exp_ftw, then checks done/busy.
   task automatic follow(input int dw, input bit noise);
      for (int p = 0; p < exp_ftw.size(); p++) begin
         chk("ftw", ftw_out, exp_ftw[p]);
         chk("idx", 32'(point_idx), p);
         chk("busy", 32'(busy), 1);
         chk("wave", 32'(wave_sel_out), 32'(exp_wave));
         tick(1);
         chk("apply_settle", 32'(apply_pulse), 0);
         if (noise) begin
            start = 1'b1;
            set_cfg(32'd7777, 32'd5, 32'd1, 24'd100, 3'd2, 1'b1);
         end
         tick(1);
         start = 1'b0;
         chk("apply_rise", 32'(apply_pulse), 1);
         tick(1);
         chk("apply_hold", 32'(apply_pulse), 1);
         tick(1);
         chk("apply_fall", 32'(apply_pulse), 0);
         tick(dw - 1);
         chk("ftw_stable", ftw_out, exp_ftw[p]);
         chk("no_done", 32'(done), 0);
         tick(1);
      end
      chk("done", 32'(done), 1);
      chk("busy_end", 32'(busy), 0);
      chk("ftw_end", ftw_out, exp_ftw[exp_ftw.size() - 1]);
      tick(1);
      chk("done_1cyc", 32'(done), 0);
   endtask

   task automatic go;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      Rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      set_cfg(32'd1000, 32'd1300, 32'd100, 24'd10, 3'd5, 1'b0);
      tick(3);
      chk("rst_ftw", ftw_out, 0);
      chk("rst_wave", 32'(wave_sel_out), 0);
      chk("rst_apply", 32'(apply_pulse), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_idx", 32'(point_idx), 0);
      Rst_n = 1'b1;
      tick(2);
      chk("idle_busy", 32'(busy), 0);

      // basic sweep
      exp_wave = 3'd5;
      exp_ftw = '{32'd1000, 32'd1100, 32'd1200, 32'd1300};
      go();
      follow(10, 1'b0);
      tick(3);
      chk("idle_after", 32'(busy), 0);

      // clamp to stop
      set_cfg(32'd1000, 32'd1250, 32'd100, 24'd10, 3'd1, 1'b0);
      exp_wave = 3'd1;
      exp_ftw = '{32'd1000, 32'd1100, 32'd1200, 32'd1250};
      go();
      follow(10, 1'b0);

      // 32-bit overflow clamps to stop
      set_cfg(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 24'd8, 3'd3, 1'b0);
      exp_wave = 3'd3;
      exp_ftw = '{32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFFFF};
      go();
      follow(8, 1'b0);

      // step=0 single point, dwell clamped to 8
      set_cfg(32'd500, 32'd900, 32'd0, 24'd3, 3'd4, 1'b0);
      exp_wave = 3'd4;
      exp_ftw = '{32'd500};
      go();
      follow(8, 1'b0);

      // start >= stop single point
      set_cfg(32'd900, 32'd500, 32'd10, 24'd8, 3'd4, 1'b0);
      exp_ftw = '{32'd900};
      go();
      follow(8, 1'b0);

      // continuous mode wraps with no gap, then abort in dwell
      set_cfg(32'd10, 32'd30, 32'd10, 24'd8, 3'd6, 1'b1);
      go();
      for (int p = 0; p < 7; p++) begin
         chk("cont_ftw", ftw_out, 32'(10 * ((p % 3) + 1)));
         chk("cont_idx", 32'(point_idx), 32'(p % 3));
         tick(6);
         chk("cont_no_done", 32'(done), 0);
         chk("cont_busy", 32'(busy), 1);
         tick(6);
      end
      tick(5);
      held_ftw = ftw_out;
      held_idx = point_idx;
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_apply", 32'(apply_pulse), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_ftw", ftw_out, held_ftw);
      chk("abort_idx", 32'(point_idx), 32'(held_idx));
      tick(20);
      chk("abort_stays", 32'(busy), 0);
      chk("abort_no_done", 32'(done), 0);

      // abort during pulse truncates it
      set_cfg(32'd1000, 32'd1300, 32'd100, 24'd10, 3'd5, 1'b0);
      go();
      tick(2);
      chk("pre_abort_apply", 32'(apply_pulse), 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("trunc_apply", 32'(apply_pulse), 0);
      chk("trunc_busy", 32'(busy), 0);
      chk("trunc_ftw", ftw_out, 32'd1000);
      tick(30);
      chk("trunc_no_done", 32'(done), 0);
      chk("trunc_idle", 32'(apply_pulse), 0);

      // abort and start together in IDLE: stay idle
      start = 1'b1; abort = 1'b1;
      tick(2);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", 32'(busy), 0);

      // restarted sweep ignores cfg changes and start pulses while busy
      exp_wave = 3'd5;
      exp_ftw = '{32'd1000, 32'd1100, 32'd1200, 32'd1300};
      go();
      follow(10, 1'b1);
      set_cfg(32'd1000, 32'd1300, 32'd100, 24'd10, 3'd5, 1'b0);
      tick(2);

      // async reset mid-dwell
      set_cfg(32'd2000, 32'd2300, 32'd100, 24'd10, 3'd7, 1'b0);
      go();
      tick(14 + 6);
      chk("pre_rst_idx", 32'(point_idx), 1);
      #2 Rst_n = 1'b0;
      #1;
      chk("arst_ftw", ftw_out, 0);
      chk("arst_wave", 32'(wave_sel_out), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_idx", 32'(point_idx), 0);
      chk("arst_apply", 32'(apply_pulse), 0);
      tick(2);
      Rst_n = 1'b1;
      tick(1);
      exp_wave = 3'd7;
      exp_ftw = '{32'd2000, 32'd2100, 32'd2200, 32'd2300};
      go();
      follow(10, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
